// File: rtl/constant.sv
// rtl/constant.sv - shared core constants, mode encodings and loader state type
package constant;

  localparam int INST_SIZE = 12;

  localparam logic [2:0] STALL = 3'd0;
  localparam logic [2:0] LOAD  = 3'd1;
  localparam logic [2:0] EXEC  = 3'd2;

  typedef enum logic [2:0] {IDLE, HDR, DATA, DONE, ERR} loader_state_t;

endpackage

// File: rtl/program_loader_if.sv
// rtl/program_loader_if.sv - instruction BRAM write port bundle
interface program_loader_if #(
  parameter int INST_SIZE = constant::INST_SIZE
);

  logic [INST_SIZE-1:0] addra;
  logic [31:0]          dina;
  logic                 wea;

  modport master (output addra, dina, wea);
  modport slave  (input  addra, dina, wea);

endinterface

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with 2-flop input synchroniser
module uart_rx #(
  parameter int CLK_PER_HALF_BIT = 434
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       rxd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_ferr
);

  localparam int FULL = 2 * CLK_PER_HALF_BIT;
  localparam int TW   = $clog2(FULL);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  rx_state_t       state, state_nx;
  logic [2:0]      sync;
  logic [TW-1:0]   timer, timer_nx;
  logic [2:0]      bit_cnt, bit_cnt_nx;
  logic [7:0]      shift, shift_nx;
  logic            valid_nx, ferr_nx;
  logic            rx, fall;

  // sync[1] is the synchronised line, sync[2] its previous value
  assign rx      = sync[1];
  assign fall    = sync[2] & ~sync[1];
  assign rx_data = shift;

  always_comb begin
    state_nx   = state;
    timer_nx   = timer + 1'b1;
    bit_cnt_nx = bit_cnt;
    shift_nx   = shift;
    valid_nx   = 1'b0;
    ferr_nx    = 1'b0;
    case (state)
      RX_IDLE: begin
        timer_nx = '0;
        if (fall) state_nx = RX_START;
      end
      RX_START: begin
        if (timer == TW'(CLK_PER_HALF_BIT - 1)) begin
          timer_nx   = '0;
          bit_cnt_nx = '0;
          state_nx   = rx ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (timer == TW'(FULL - 1)) begin
          timer_nx   = '0;
          shift_nx   = {rx, shift[7:1]};
          bit_cnt_nx = bit_cnt + 1'b1;
          if (bit_cnt == 3'd7) state_nx = RX_STOP;
        end
      end
      RX_STOP: begin
        if (timer == TW'(FULL - 1)) begin
          timer_nx = '0;
          state_nx = RX_IDLE;
          valid_nx = rx;
          ferr_nx  = ~rx;
        end
      end
      default: state_nx = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= RX_IDLE;
      sync     <= '0;
      timer    <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      rx_valid <= 1'b0;
      rx_ferr  <= 1'b0;
    end else begin
      state    <= state_nx;
      sync     <= {sync[1:0], rxd};
      timer    <= timer_nx;
      bit_cnt  <= bit_cnt_nx;
      shift    <= shift_nx;
      rx_valid <= valid_nx;
      rx_ferr  <= ferr_nx;
    end
  end

endmodule

// File: rtl/program_loader.sv
// rtl/program_loader.sv - receives a length-prefixed program image over UART into instruction BRAM
module program_loader #(
  parameter int CLK_PER_HALF_BIT = 434,
  parameter int INST_SIZE        = constant::INST_SIZE
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [2:0]            mode,
  input  logic                  rxd,
  program_loader_if.master      bram,
  output logic                  done,
  output logic                  err,
  output logic [INST_SIZE:0]    words_loaded
);

  import constant::*;

  localparam logic [32:0] DEPTH = 33'd1 << INST_SIZE;

  loader_state_t         state, state_nx;
  logic [1:0]            byte_cnt;
  logic [31:0]           shreg;
  logic [31:0]           assembled;
  logic [INST_SIZE:0]    n_words;
  logic [INST_SIZE-1:0]  addr;
  logic [31:0]           data;
  logic                  we;
  logic [7:0]            rx_data;
  logic                  rx_valid, rx_ferr;
  logic                  in_load, last_byte, last_word;

  uart_rx #(.CLK_PER_HALF_BIT(CLK_PER_HALF_BIT)) u_rx (
    .clk      (clk),
    .rstn     (rstn),
    .rxd      (rxd),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ferr  (rx_ferr)
  );

  // Bytes arrive little-endian, so each new byte enters at the top and shifts down
  assign assembled = {rx_data, shreg[31:8]};
  assign in_load   = (mode == LOAD);
  assign last_byte = rx_valid && (byte_cnt == 2'd3);
  assign last_word = we && ((words_loaded + 1'b1) == n_words);

  assign done       = (state == DONE);
  assign err        = (state == ERR);
  assign bram.addra = addr;
  assign bram.dina  = data;
  assign bram.wea   = we;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (in_load) state_nx = HDR;
      HDR: begin
        if (!in_load)                                state_nx = IDLE;
        else if (rx_ferr)                            state_nx = ERR;
        else if (last_byte) begin
          if (assembled == 32'd0)                    state_nx = DONE;
          else if ({1'b0, assembled} > DEPTH)        state_nx = ERR;
          else                                       state_nx = DATA;
        end
      end
      DATA: begin
        if (!in_load)                                state_nx = IDLE;
        else if (rx_ferr)                            state_nx = ERR;
        else if (last_word)                          state_nx = DONE;
      end
      DONE: if (!in_load) state_nx = IDLE;
      ERR:  state_nx = ERR;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state        <= IDLE;
      byte_cnt     <= '0;
      shreg        <= '0;
      n_words      <= '0;
      addr         <= '0;
      data         <= '0;
      we           <= 1'b0;
      words_loaded <= '0;
    end else begin
      state <= state_nx;
      we    <= 1'b0;
      if (state == IDLE && state_nx == HDR) begin
        byte_cnt     <= '0;
        words_loaded <= '0;
      end else if ((state == HDR || state == DATA) && rx_valid) begin
        byte_cnt <= byte_cnt + 1'b1;
        shreg    <= assembled;
      end
      if (state == HDR && state_nx == DATA) begin
        n_words <= assembled[INST_SIZE:0];
        addr    <= '0;
      end
      if (state == DATA && state_nx == DATA && last_byte) begin
        we   <= 1'b1;
        data <= assembled;
      end
      // Address holds on the final word so a full-depth image ends at depth-1
      if (we) begin
        words_loaded <= words_loaded + 1'b1;
        if (!last_word) addr <= addr + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// tb/tb_program_loader.sv - randomized self-checking bench for program_loader
module tb_program_loader;

  import constant::*;

  localparam int H     = 4;
  localparam int IS    = 4;
  localparam int DEPTH = 1 << IS;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic [2:0]    mode = STALL;
  logic          rxd = 1'b1;
  logic          done, err;
  logic [IS:0]   words_loaded;

  program_loader_if #(.INST_SIZE(IS)) bram ();

  program_loader #(.CLK_PER_HALF_BIT(H), .INST_SIZE(IS)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .mode         (mode),
    .rxd          (rxd),
    .bram         (bram),
    .done         (done),
    .err          (err),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int last_we_cyc = 0;
  int done_rise_cyc = 0;
  int wea_long = 0;
  logic done_d = 1'b0;
  logic wea_d = 1'b0;
  logic [IS-1:0] wr_addr[$];
  logic [31:0]   wr_data[$];

  always @(posedge clk) cyc = cyc + 1;

  always @(negedge clk) begin
    if (bram.wea === 1'b1) begin
      wr_addr.push_back(bram.addra);
      wr_data.push_back(bram.dina);
      last_we_cyc = cyc;
      if (wea_d) wea_long = wea_long + 1;
    end
    if (done === 1'b1 && !done_d) done_rise_cyc = cyc;
    done_d = (done === 1'b1);
    wea_d  = (bram.wea === 1'b1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    rxd = b;
    repeat (2 * H) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop = 1'b1);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(stop);
    send_bit(1'b1);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
  endtask

  task automatic do_reset();
    mode = STALL;
    rxd  = 1'b1;
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
  endtask

  // Reference: header N, then words land at consecutive addresses from 0 if N fits the BRAM
  task automatic load_and_check(input string tag, input int n, input logic [31:0] words[$]);
    int exp_writes;
    bit fits;
    wr_addr.delete();
    wr_data.delete();
    mode = LOAD;
    repeat (4) @(negedge clk);
    send_word(n);
    foreach (words[i]) send_word(words[i]);
    repeat (20) @(negedge clk);
    fits       = (n <= DEPTH);
    exp_writes = fits ? n : 0;
    check({tag, ":nwrites"}, wr_addr.size(), exp_writes);
    for (int i = 0; i < wr_addr.size() && i < exp_writes; i++) begin
      check($sformatf("%s:addr%0d", tag, i), wr_addr[i], i);
      check($sformatf("%s:data%0d", tag, i), wr_data[i], words[i]);
    end
    check({tag, ":done"}, done, fits);
    check({tag, ":err"}, err, !fits);
    if (fits) check({tag, ":words_loaded"}, words_loaded, n);
    if (fits && n > 0) check({tag, ":done_lat"}, done_rise_cyc - last_we_cyc, 1);
  endtask

  task automatic leave_load(input string tag, input int exp_words);
    mode = EXEC;
    repeat (4) @(negedge clk);
    check({tag, ":done_clr"}, done, 1'b0);
    check({tag, ":wl_hold"}, words_loaded, exp_words);
  endtask

  initial begin
    logic [31:0] w[$];
    logic [31:0] wa, wb;
    int n;

    repeat (3) @(negedge clk);
    check("rst:addra", bram.addra, 0);
    check("rst:dina", bram.dina, 0);
    check("rst:wea", bram.wea, 0);
    check("rst:done", done, 0);
    check("rst:err", err, 0);
    check("rst:words_loaded", words_loaded, 0);
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    w = {32'h12345678, 32'hDEADBEEF};
    load_and_check("basic", 2, w);
    leave_load("basic", 2);

    w = {};
    load_and_check("zero", 0, w);
    leave_load("zero", 0);

    for (int r = 0; r < 3; r++) begin
      n = int'($urandom_range(1, DEPTH - 1));
      w = {};
      for (int i = 0; i < n; i++) w.push_back($urandom);
      load_and_check($sformatf("rand%0d", r), n, w);
      leave_load($sformatf("rand%0d", r), n);
    end

    w = {};
    for (int i = 0; i < DEPTH; i++) w.push_back($urandom);
    load_and_check("full", DEPTH, w);
    check("full:last_addra", bram.addra, DEPTH - 1);
    leave_load("full", DEPTH);

    do_reset();
    w = {$urandom, $urandom};
    load_and_check("over", DEPTH + 1, w);
    mode = EXEC;
    repeat (4) @(negedge clk);
    check("over:err_sticky", err, 1'b1);
    do_reset();
    check("over:err_rst", err, 1'b0);

    wr_addr.delete();
    wr_data.delete();
    mode = LOAD;
    repeat (4) @(negedge clk);
    send_word(3);
    wa = $urandom;
    send_byte(wa[7:0]);
    send_byte(wa[15:8]);
    send_byte(wa[23:16], 1'b0);
    send_byte(wa[31:24]);
    send_word($urandom);
    send_word($urandom);
    repeat (20) @(negedge clk);
    check("fe:err", err, 1'b1);
    check("fe:nwrites", wr_addr.size(), 0);
    check("fe:done", done, 1'b0);
    mode = EXEC;
    repeat (4) @(negedge clk);
    mode = LOAD;
    repeat (4) @(negedge clk);
    check("fe:err_sticky", err, 1'b1);
    do_reset();
    check("fe:err_rst", err, 1'b0);

    wr_addr.delete();
    wr_data.delete();
    mode = LOAD;
    repeat (4) @(negedge clk);
    send_word(2);
    wa = $urandom;
    wb = $urandom;
    send_word(wa);
    send_byte(wb[7:0]);
    send_byte(wb[15:8]);
    mode = EXEC;
    repeat (4) @(negedge clk);
    check("abort:done", done, 1'b0);
    check("abort:nwrites", wr_addr.size(), 1);
    if (wr_addr.size() > 0) begin
      check("abort:addr0", wr_addr[0], 0);
      check("abort:data0", wr_data[0], wa);
    end
    send_byte(wb[23:16]);
    send_byte(wb[31:24]);
    repeat (20) @(negedge clk);
    check("abort:no_more", wr_addr.size(), 1);
    w = {32'hAABBCCDD};
    load_and_check("restart", 1, w);
    leave_load("restart", 1);

    mode = LOAD;
    repeat (4) @(negedge clk);
    send_word(2);
    send_word($urandom);
    repeat (10) @(negedge clk);
    check("areset:wl_pre", words_loaded, 1);
    send_bit(1'b0);
    send_bit(1'b1);
    #2 rstn = 1'b0;
    #1;
    check("areset:addra", bram.addra, 0);
    check("areset:dina", bram.dina, 0);
    check("areset:wea", bram.wea, 0);
    check("areset:done", done, 0);
    check("areset:err", err, 0);
    check("areset:words_loaded", words_loaded, 0);
    rxd = 1'b1;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    repeat (4) @(negedge clk);
    rxd = 1'b0;
    @(negedge clk);
    rxd = 1'b1;
    repeat (40) @(negedge clk);
    w = {$urandom};
    load_and_check("glitch", 1, w);

    check("wea_single_cycle", wea_long, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
